i2c_slave_regs: RTL and testbench
=================================

# i2c_slave_regs

System-clocked I2C target giving an external register bank byte-addressed access, with multi-byte bursts, pointer auto-increment, repeated START and NACK handling. It supersedes the SCL-clocked single-byte slave. SCL and SDA are oversampled on `clk`, so the block sits in the `clk` domain next to the registers it serves. The top level provides the open-drain pad (SDA low when `sda_oe`=1).

## Interface
- `REG_AW`, 4: register pointer width; bank depth is 2^REG_AW bytes.
- `FILT`, 3: glitch-filter length in `clk` cycles, minimum 1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `addr`  in  7  own device address, static during a transaction.
- `scl_i`  in  1  raw SCL from the pad (asynchronous).
- `sda_i`  in  1  raw SDA from the pad (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low, 0 = release.
- `wr_en`  out  1  one-cycle write strobe.
- `wr_addr`  out  REG_AW  write register index.
- `wr_data`  out  8  write data.
- `rd_addr`  out  REG_AW  current pointer; the bank returns `rd_data` combinationally.
- `rd_data`  in  8  read data for `rd_addr`.
- `rd_strobe`  out  1  one-cycle pulse when `rd_data` is captured for transmit.
- `busy`  out  1  high from a START that addresses this device until STOP.
- `done`  out  1  one-cycle pulse on STOP after an addressed transaction.

## Operation
- Front end:
  - 2-FF synchroniser, then the FILT filter; the filtered level changes only after FILT equal consecutive samples.
  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- FSM states: IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WR_BYTE, ACK_WR, RD_BYTE, RD_ACK, IGNORE.
- START in any state goes to ADDR and resets the bit counter. This is how repeated START works.
- STOP in any state goes to IDLE and releases SDA. It pulses `done` if `busy` was high.
- ADDR: shift 8 bits, MSB first, sampling on SCL rise.
  - Upper 7 bits equal `addr`: go to ACK_ADDR and drive ACK (0).
  - Mismatch: go to IGNORE and do not drive SDA.
- After ACK_ADDR:
  - R/W=0 goes to PTR. The first data byte loads the pointer; the low REG_AW bits are kept and the upper bits are ignored. ACK it.
  - Following bytes go WR_BYTE → ACK_WR: `wr_en` pulses with `wr_addr`=pointer and `wr_data`=byte, then pointer+1.
  - R/W=1 goes to RD_BYTE.
- RD_BYTE:
  - On the SCL fall that ends the ACK/RD_ACK slot, capture `rd_data`, pulse `rd_strobe`, pointer+1.
  - Shift 8 bits out MSB first. Only drive SDA low for a 0 bit.
- RD_ACK: release SDA and sample the master bit on SCL rise.
  - 0 (ACK): next byte.
  - 1 (NACK): go to IGNORE and wait for STOP or START.
- Pointer wraps 2^REG_AW−1 → 0. It keeps its value across transactions; only a write-mode pointer byte or reset changes it.
- Write-mode transaction with only the pointer byte: no `wr_en`. The new pointer is used by a following read (repeated START).

## Timing
- Reset values: `sda_oe`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_strobe`=0, `busy`=0, `done`=0, pointer=0, state IDLE.
- `rst` mid-transaction: SDA is released on the next `clk` edge. The block ignores the bus until the next START.
- Input latency: pad to filtered edge is 2+FILT `clk` cycles.
- `sda_oe` updates one `clk` after the filtered SCL fall. It is never changed while SCL is high, except on STOP/START/reset.
- `wr_en` asserts one `clk` after the filtered SCL rise that samples data bit 0.
- `rd_data` must be valid in the same cycle as `rd_strobe`.
- Bus limits: SCL low and high each ≥ FILT+4 `clk` cycles. No clock stretching.
- `done` pulses one `clk` after STOP is detected.
- Simultaneous STOP and internal `wr_en` cannot occur. The byte write commits before the ACK slot ends.

## Structure
- Package `i2c_pkg`:
  - FSM state enum.
  - Constants `I2C_ACK`=0, `I2C_NACK`=1, `I2C_RD`=1, `I2C_WR`=0.
- Sub-module `i2c_bus_filter`: synchroniser, FILT filter, SCL rise/fall strobes, START/STOP strobes. Reused by a future master.
- Top level: FSM, bit counter (3 bits), shift register, pointer.

## Test plan
- Write burst: START, 0x1E (addr 0x0F, W), pointer 0x02, data 0xAB, 0xCD, STOP → ACK on every byte; `wr_en`×2 at addr 2=0xAB, addr 3=0xCD; `done` pulses once.
- Read with repeated START: write pointer 0x0E, Sr, 0x1F, master ACK, ACK, NACK, STOP → bytes reg[14], reg[15], reg[0] transmitted (wrap); `rd_strobe`×3.
- Address mismatch: `addr`=0x0F, bus sends 0x20 → `sda_oe` stays 0 throughout; no `wr_en`; `busy`=0; `done` does not pulse.
- Glitch: 1-cycle low pulse on SCL while SDA is stable, with FILT=3 → no bit shifted; the transaction completes correctly.
- Reset mid-read (during bit 3 of a 0x00 byte, while `sda_oe`=1) → `sda_oe`=0 the next cycle; pointer=0; the next START/0x1E transaction is ACKed.
- STOP right after the address ACK → no `wr_en`; `done` pulses; pointer unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the system-clocked I2C target: FSM states,
// bus-level constants and the address-compare helper.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ACK_ADDR = 4'd2,
        ST_PTR      = 4'd3,
        ST_ACK_PTR  = 4'd4,
        ST_WR_BYTE  = 4'd5,
        ST_ACK_WR   = 4'd6,
        ST_RD_BYTE  = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic I2C_RD   = 1'b1;
    localparam logic I2C_WR   = 1'b0;

    // Upper seven bits of the address frame select the device.
    function automatic logic addr_match(input logic [7:0] frame, input logic [6:0] own);
        return (frame[7:1] == own);
    endfunction

endpackage

// File: rtl/i2c_bus_filter.sv
// SCL/SDA front end: two-stage synchroniser, FILT-sample glitch filter,
// SCL edge strobes and START/STOP detection, all in the clk domain.
module i2c_bus_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

    // Index 0 is SCL, index 1 is SDA. Idle bus level is high.
    logic [1:0]    meta_r;
    logic [1:0]    sync_r;
    logic [1:0]    lvl_r;
    logic [1:0]    prev_r;
    logic [CW-1:0] cnt_r [2];

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 2'b11;
            sync_r <= 2'b11;
        end else begin
            meta_r <= {sda_i, scl_i};
            sync_r <= meta_r;
        end
    end

    // Filtered level follows the synchronised input only after FILT equal samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_r    <= 2'b11;
            prev_r   <= 2'b11;
            cnt_r[0] <= {CW{1'b0}};
            cnt_r[1] <= {CW{1'b0}};
        end else begin
            prev_r <= lvl_r;
            for (int i = 0; i < 2; i++) begin
                if (sync_r[i] == lvl_r[i]) begin
                    cnt_r[i] <= {CW{1'b0}};
                end else if (cnt_r[i] == CW'(FILT - 1)) begin
                    lvl_r[i] <= sync_r[i];
                    cnt_r[i] <= {CW{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end
            end
        end
    end

    assign sda_lvl   = lvl_r[1];
    assign scl_rise  = lvl_r[0] & ~prev_r[0];
    assign scl_fall  = ~lvl_r[0] & prev_r[0];
    // SCL must be high before and after the SDA transition.
    assign start_det = prev_r[1] & ~lvl_r[1] & lvl_r[0] & prev_r[0];
    assign stop_det  = ~prev_r[1] & lvl_r[1] & lvl_r[0] & prev_r[0];

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing a 2^REG_AW byte register bank: pointer byte then
// burst writes, or burst reads from the pointer, with auto-increment.
module i2c_slave_regs #(
    parameter int REG_AW = 4,
    parameter int FILT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        addr,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [REG_AW-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              rd_strobe,
    output logic              busy,
    output logic              done
);

    import i2c_pkg::*;

    logic sda_lvl_s;
    logic scl_rise_s;
    logic scl_fall_s;
    logic start_s;
    logic stop_s;

    i2c_bus_filter #(.FILT(FILT)) u_filter (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_lvl   (sda_lvl_s),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_s),
        .stop_det  (stop_s)
    );

    i2c_state_e        state_r, state_nx_s;
    logic [2:0]        bit_cnt_r, bit_cnt_nx_s;
    logic [7:0]        shift_r, shift_nx_s;
    logic [7:0]        tx_r, tx_nx_s;
    logic [REG_AW-1:0] ptr_r, ptr_nx_s;
    // In ACK states: ACK already driven. In RD_ACK: master acknowledged.
    logic              slot_r, slot_nx_s;
    logic              rw_r, rw_nx_s;
    logic              sda_oe_nx_s;
    logic              wr_en_nx_s;
    logic [REG_AW-1:0] wr_addr_nx_s;
    logic [7:0]        wr_data_nx_s;
    logic              rd_strobe_nx_s;
    logic              busy_nx_s;
    logic              done_nx_s;
    logic [7:0]        shifted_s;

    assign shifted_s = {shift_r[6:0], sda_lvl_s};
    assign rd_addr   = ptr_r;

    // Next-state and next-output decode, driven by bus events.
    always_comb begin
        state_nx_s     = state_r;
        bit_cnt_nx_s   = bit_cnt_r;
        shift_nx_s     = shift_r;
        tx_nx_s        = tx_r;
        slot_nx_s      = slot_r;
        rw_nx_s        = rw_r;
        sda_oe_nx_s    = sda_oe;
        wr_en_nx_s     = 1'b0;
        wr_addr_nx_s   = wr_addr;
        wr_data_nx_s   = wr_data;
        rd_strobe_nx_s = 1'b0;
        busy_nx_s      = busy;
        done_nx_s      = 1'b0;
        // The pointer advances while rd_strobe is high so rd_addr/rd_data
        // still describe the captured byte during the strobe.
        if (rd_strobe) begin
            ptr_nx_s = ptr_r + REG_AW'(1);
        end else begin
            ptr_nx_s = ptr_r;
        end

        if (stop_s) begin
            state_nx_s  = ST_IDLE;
            sda_oe_nx_s = 1'b0;
            busy_nx_s   = 1'b0;
            done_nx_s   = busy;
        end else if (start_s) begin
            state_nx_s   = ST_ADDR;
            bit_cnt_nx_s = 3'd0;
            sda_oe_nx_s  = 1'b0;
        end else if (scl_rise_s) begin
            case (state_r)
                ST_ADDR, ST_PTR, ST_WR_BYTE: begin
                    shift_nx_s   = shifted_s;
                    bit_cnt_nx_s = bit_cnt_r + 3'd1;
                    slot_nx_s    = 1'b0;
                    if (bit_cnt_r != 3'd7) begin
                        state_nx_s = state_r;
                    end else if (state_r == ST_ADDR) begin
                        if (addr_match(shifted_s, addr)) begin
                            state_nx_s = ST_ACK_ADDR;
                            rw_nx_s    = shifted_s[0];
                            busy_nx_s  = 1'b1;
                        end else begin
                            state_nx_s = ST_IGNORE;
                        end
                    end else if (state_r == ST_PTR) begin
                        ptr_nx_s   = shifted_s[REG_AW-1:0];
                        state_nx_s = ST_ACK_PTR;
                    end else begin
                        wr_en_nx_s   = 1'b1;
                        wr_addr_nx_s = ptr_r;
                        wr_data_nx_s = shifted_s;
                        ptr_nx_s     = ptr_r + REG_AW'(1);
                        state_nx_s   = ST_ACK_WR;
                    end
                end
                ST_RD_BYTE: begin
                    tx_nx_s      = {tx_r[6:0], 1'b0};
                    bit_cnt_nx_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_nx_s = ST_RD_ACK;
                        slot_nx_s  = 1'b0;
                    end else begin
                        state_nx_s = ST_RD_BYTE;
                    end
                end
                ST_RD_ACK: begin
                    if (sda_lvl_s == I2C_ACK) begin
                        slot_nx_s = 1'b1;
                    end else begin
                        state_nx_s = ST_IGNORE;
                    end
                end
                default: begin
                    state_nx_s = state_r;
                end
            endcase
        end else if (scl_fall_s) begin
            case (state_r)
                ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_WR: begin
                    if (!slot_r) begin
                        sda_oe_nx_s = 1'b1;
                        slot_nx_s   = 1'b1;
                    end else if (state_r == ST_ACK_ADDR && rw_r == I2C_RD) begin
                        tx_nx_s        = rd_data;
                        sda_oe_nx_s    = ~rd_data[7];
                        rd_strobe_nx_s = 1'b1;
                        bit_cnt_nx_s   = 3'd0;
                        state_nx_s     = ST_RD_BYTE;
                    end else if (state_r == ST_ACK_ADDR && rw_r == I2C_WR) begin
                        sda_oe_nx_s  = 1'b0;
                        bit_cnt_nx_s = 3'd0;
                        state_nx_s   = ST_PTR;
                    end else begin
                        sda_oe_nx_s  = 1'b0;
                        bit_cnt_nx_s = 3'd0;
                        state_nx_s   = ST_WR_BYTE;
                    end
                end
                ST_RD_BYTE: begin
                    sda_oe_nx_s = ~tx_r[7];
                end
                ST_RD_ACK: begin
                    if (slot_r) begin
                        tx_nx_s        = rd_data;
                        sda_oe_nx_s    = ~rd_data[7];
                        rd_strobe_nx_s = 1'b1;
                        bit_cnt_nx_s   = 3'd0;
                        state_nx_s     = ST_RD_BYTE;
                    end else begin
                        sda_oe_nx_s = 1'b0;
                    end
                end
                default: begin
                    state_nx_s = state_r;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 8'h00;
            ptr_r     <= {REG_AW{1'b0}};
            slot_r    <= 1'b0;
            rw_r      <= 1'b0;
            sda_oe    <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= {REG_AW{1'b0}};
            wr_data   <= 8'h00;
            rd_strobe <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            shift_r   <= shift_nx_s;
            tx_r      <= tx_nx_s;
            ptr_r     <= ptr_nx_s;
            slot_r    <= slot_nx_s;
            rw_r      <= rw_nx_s;
            sda_oe    <= sda_oe_nx_s;
            wr_en     <= wr_en_nx_s;
            wr_addr   <= wr_addr_nx_s;
            wr_data   <= wr_data_nx_s;
            rd_strobe <= rd_strobe_nx_s;
            busy      <= busy_nx_s;
            done      <= done_nx_s;
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, behavioural register
// bank, table of write transactions plus read/reset sequences.
module tb_i2c_slave_regs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] addr = 7'h0F;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_strobe;
    logic       busy;
    logic       done;

    logic       bank_init = 1'b1;
    logic [7:0] bank [16];

    int n_tests = 0;
    int n_fail  = 0;

    int          wr_n = 0, rd_n = 0, done_n = 0, busy_cyc = 0, oe_cyc = 0;
    logic [11:0] wr_log [64];
    logic [11:0] rd_log [64];

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;
    assign rd_data = bank[rd_addr];

    i2c_slave_regs #(.REG_AW(4), .FILT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_strobe (rd_strobe),
        .busy      (busy),
        .done      (done)
    );

    // Register bank: reg[i] = {i, ~i}, except reg[5] = 0x00.
    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < 16; i++) begin
                bank[i] <= (i == 5) ? 8'h00 : {4'(i), ~4'(i)};
            end
        end else if (wr_en) begin
            bank[wr_addr] <= wr_data;
        end
    end

    // Event monitor: logs strobes and counts busy / sda_oe cycles.
    always @(negedge clk) begin
        if (wr_en && wr_n < 64) begin
            wr_log[wr_n] <= {wr_addr, wr_data};
            wr_n <= wr_n + 1;
        end
        if (rd_strobe && rd_n < 64) begin
            rd_log[rd_n] <= {rd_addr, rd_data};
            rd_n <= rd_n + 1;
        end
        if (done) done_n <= done_n + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (sda_oe) oe_cyc <= oe_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(10);
        scl_m = 1'b1; wait_clk(10);
        sda_m = 1'b0; wait_clk(10);
        scl_m = 1'b0; wait_clk(10);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(10);
        scl_m = 1'b1; wait_clk(10);
        sda_m = 1'b1; wait_clk(30);
    endtask

    // g inserts a one-cycle low glitch in the middle of the SCL high phase.
    task automatic send_bit(input logic b, input logic g);
        sda_m = b; wait_clk(10);
        scl_m = 1'b1;
        if (g) begin
            wait_clk(5); scl_m = 1'b0; wait_clk(1); scl_m = 1'b1; wait_clk(9);
        end else begin
            wait_clk(15);
        end
        scl_m = 1'b0; wait_clk(10);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clk(10);
        scl_m = 1'b1; wait_clk(8);
        b = sda_bus;  wait_clk(7);
        scl_m = 1'b0; wait_clk(10);
    endtask

    task automatic write_byte(input logic [7:0] v, input logic g, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(v[i], g);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            v[i] = b;
        end
        send_bit(mack, 1'b0);
    endtask

    typedef struct {
        logic [7:0] dev;
        int         nbytes;
        logic [7:0] b0, b1, b2;
        logic       glitch;
        logic       exp_ack;
        int         exp_wr;
        logic [3:0] a0; logic [7:0] d0;
        logic [3:0] a1; logic [7:0] d1;
        int         exp_done;
        logic [3:0] exp_ptr;
    } wvec_t;

    wvec_t vec [6];

    task automatic run_vec(input int k, input wvec_t v);
        int   w0, d0, bc0, oc0;
        logic ack;
        logic [7:0] byt;
        w0 = wr_n; d0 = done_n; bc0 = busy_cyc; oc0 = oe_cyc;
        i2c_start();
        write_byte(v.dev, v.glitch, ack);
        check($sformatf("v%0d addr ack", k), {31'd0, ack}, {31'd0, v.exp_ack});
        for (int j = 0; j < v.nbytes; j++) begin
            byt = (j == 0) ? v.b0 : ((j == 1) ? v.b1 : v.b2);
            write_byte(byt, v.glitch, ack);
            check($sformatf("v%0d byte%0d ack", k, j), {31'd0, ack}, {31'd0, v.exp_ack});
        end
        i2c_stop();
        check($sformatf("v%0d wr_en count", k), wr_n - w0, v.exp_wr);
        if (v.exp_wr >= 1) check($sformatf("v%0d write0", k), {20'd0, wr_log[w0]}, {20'd0, v.a0, v.d0});
        if (v.exp_wr >= 2) check($sformatf("v%0d write1", k), {20'd0, wr_log[w0 + 1]}, {20'd0, v.a1, v.d1});
        check($sformatf("v%0d done count", k), done_n - d0, v.exp_done);
        check($sformatf("v%0d pointer", k), {28'd0, rd_addr}, {28'd0, v.exp_ptr});
        if (v.exp_ack) begin
            check($sformatf("v%0d busy cycles", k), busy_cyc - bc0, 0);
            check($sformatf("v%0d sda_oe cycles", k), oe_cyc - oc0, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] rb;
        int         r0, w0, d0;

        vec[0] = '{8'h1E, 3, 8'h02, 8'hAB, 8'hCD, 1'b0, 1'b0, 2, 4'h2, 8'hAB, 4'h3, 8'hCD, 1, 4'h4};
        vec[1] = '{8'h1E, 3, 8'h9F, 8'h11, 8'h22, 1'b0, 1'b0, 2, 4'hF, 8'h11, 4'h0, 8'h22, 1, 4'h1};
        vec[2] = '{8'h20, 3, 8'h02, 8'h55, 8'h66, 1'b0, 1'b1, 0, 4'h0, 8'h00, 4'h0, 8'h00, 0, 4'h1};
        vec[3] = '{8'h1E, 1, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 0, 4'h0, 8'h00, 4'h0, 8'h00, 1, 4'h5};
        vec[4] = '{8'h1E, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0, 4'h0, 8'h00, 4'h0, 8'h00, 1, 4'h5};
        vec[5] = '{8'h1E, 3, 8'h07, 8'h5A, 8'h3C, 1'b1, 1'b0, 2, 4'h7, 8'h5A, 4'h8, 8'h3C, 1, 4'h9};

        // Reset state.
        wait_clk(4);
        check("reset sda_oe",    {31'd0, sda_oe},    32'd0);
        check("reset wr_en",     {31'd0, wr_en},     32'd0);
        check("reset wr_addr",   {28'd0, wr_addr},   32'd0);
        check("reset wr_data",   {24'd0, wr_data},   32'd0);
        check("reset rd_strobe", {31'd0, rd_strobe}, 32'd0);
        check("reset busy",      {31'd0, busy},      32'd0);
        check("reset done",      {31'd0, done},      32'd0);
        check("reset pointer",   {28'd0, rd_addr},   32'd0);
        rst = 1'b0;
        bank_init = 1'b0;
        wait_clk(20);

        // Write transactions from the table.
        for (int k = 0; k < 6; k++) run_vec(k, vec[k]);

        // Read with repeated START: pointer 0x0E, then three bytes with wrap.
        // reg[15] and reg[0] hold 0x11 / 0x22 from vector 1.
        r0 = rd_n; w0 = wr_n; d0 = done_n;
        i2c_start();
        write_byte(8'h1E, 1'b0, ack); check("rd addr-w ack", {31'd0, ack}, 32'd0);
        write_byte(8'h0E, 1'b0, ack); check("rd ptr ack", {31'd0, ack}, 32'd0);
        i2c_start();
        write_byte(8'h1F, 1'b0, ack); check("rd addr-r ack", {31'd0, ack}, 32'd0);
        check("rd busy", {31'd0, busy}, 32'd1);
        read_byte(rb, 1'b0); check("rd byte0", {24'd0, rb}, 32'hE1);
        read_byte(rb, 1'b0); check("rd byte1", {24'd0, rb}, 32'h11);
        read_byte(rb, 1'b1); check("rd byte2", {24'd0, rb}, 32'h22);
        i2c_stop();
        check("rd strobe count", rd_n - r0, 3);
        check("rd strobe0", {20'd0, rd_log[r0]},     {20'd0, 4'hE, 8'hE1});
        check("rd strobe1", {20'd0, rd_log[r0 + 1]}, {20'd0, 4'hF, 8'h11});
        check("rd strobe2", {20'd0, rd_log[r0 + 2]}, {20'd0, 4'h0, 8'h22});
        check("rd wr_en count", wr_n - w0, 0);
        check("rd done count", done_n - d0, 1);
        check("rd pointer", {28'd0, rd_addr}, 32'd1);

        // Reset while transmitting a 0 bit of reg[5] = 0x00.
        i2c_start();
        write_byte(8'h1E, 1'b0, ack); check("rst addr ack", {31'd0, ack}, 32'd0);
        write_byte(8'h05, 1'b0, ack); check("rst ptr ack", {31'd0, ack}, 32'd0);
        i2c_start();
        write_byte(8'h1F, 1'b0, ack); check("rst addr-r ack", {31'd0, ack}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            recv_bit(b);
            check($sformatf("rst bit%0d", 7 - i), {31'd0, b}, 32'd0);
        end
        sda_m = 1'b1;
        wait_clk(2);
        check("rst sda_oe before", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("rst sda_oe after", {31'd0, sda_oe}, 32'd0);
        check("rst pointer", {28'd0, rd_addr}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        wait_clk(10);
        scl_m = 1'b1;
        wait_clk(30);
        d0 = done_n;
        i2c_start();
        write_byte(8'h1E, 1'b0, ack); check("post-rst addr ack", {31'd0, ack}, 32'd0);
        write_byte(8'h03, 1'b0, ack); check("post-rst ptr ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        check("post-rst done count", done_n - d0, 1);
        check("post-rst pointer", {28'd0, rd_addr}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
